// File: rtl/alu_input_sequencer.sv
// Push-button operand/opcode loader with single-cycle registered ALU execution.
// Loads on button rising edges, fires once A, B and OP are all loaded, holds the result.
module alu_input_sequencer #(
  parameter int BITS_DATA = 8,
  parameter int BITS_OP   = 6,
  parameter int BUTTONS   = 3
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [BITS_DATA-1:0] i_switches,
  input  logic [BUTTONS-1:0]   i_buttons,
  output logic [BITS_DATA-1:0] o_result,
  output logic                 o_zero,
  output logic                 o_carry,
  output logic                 o_overflow,
  output logic                 o_err,
  output logic                 o_valid,
  output logic [1:0]           o_state
);

  localparam int MSB = BITS_DATA - 1;

  localparam logic [BITS_OP-1:0] OP_ADD = BITS_OP'(6'b100000);
  localparam logic [BITS_OP-1:0] OP_SUB = BITS_OP'(6'b100010);
  localparam logic [BITS_OP-1:0] OP_AND = BITS_OP'(6'b100100);
  localparam logic [BITS_OP-1:0] OP_OR  = BITS_OP'(6'b100101);
  localparam logic [BITS_OP-1:0] OP_XOR = BITS_OP'(6'b100110);
  localparam logic [BITS_OP-1:0] OP_NOR = BITS_OP'(6'b100111);
  localparam logic [BITS_OP-1:0] OP_SRA = BITS_OP'(6'b000011);
  localparam logic [BITS_OP-1:0] OP_SRL = BITS_OP'(6'b000010);

  localparam logic [BITS_DATA-1:0] SHIFT_LIM = BITS_DATA'(BITS_DATA);

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    EXEC    = 2'b01,
    HOLD    = 2'b10
  } state_t;

  state_t state, next_state;

  logic [BUTTONS-1:0]   btn_q;
  logic [BUTTONS-1:0]   rise;
  logic [2:0]           rise_abo;
  logic [2:0]           ld_flags;
  logic [2:0]           flags_after;
  logic                 load_en;
  logic [BITS_DATA-1:0] reg_a;
  logic [BITS_DATA-1:0] reg_b;
  logic [BITS_OP-1:0]   reg_op;

  logic [BITS_DATA:0]   sum_ext;
  logic [BITS_DATA:0]   diff_ext;
  logic [BITS_DATA-1:0] alu_result;
  logic                 alu_carry;
  logic                 alu_ovf;
  logic                 alu_err;

  assign rise     = i_buttons & ~btn_q;
  assign rise_abo = rise[2:0];
  assign load_en  = (state != EXEC);
  assign o_state  = state;

  assign sum_ext  = {1'b0, reg_a} + {1'b0, reg_b};
  assign diff_ext = {1'b0, reg_a} - {1'b0, reg_b};

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (reg_op)
      OP_ADD: begin
        alu_result = sum_ext[MSB:0];
        alu_carry  = sum_ext[BITS_DATA];
        alu_ovf    = (reg_a[MSB] == reg_b[MSB]) && (sum_ext[MSB] != reg_a[MSB]);
      end
      OP_SUB: begin
        alu_result = diff_ext[MSB:0];
        // The extra bit of the widened difference is the unsigned borrow.
        alu_carry  = diff_ext[BITS_DATA];
        alu_ovf    = (reg_a[MSB] != reg_b[MSB]) && (diff_ext[MSB] != reg_a[MSB]);
      end
      OP_AND: alu_result = reg_a & reg_b;
      OP_OR:  alu_result = reg_a | reg_b;
      OP_XOR: alu_result = reg_a ^ reg_b;
      OP_NOR: alu_result = ~(reg_a | reg_b);
      OP_SRA: begin
        if (reg_b >= SHIFT_LIM)
          alu_result = {BITS_DATA{reg_a[MSB]}};
        else
          alu_result = $signed(reg_a) >>> reg_b;
      end
      OP_SRL: begin
        if (reg_b >= SHIFT_LIM)
          alu_result = '0;
        else
          alu_result = reg_a >> reg_b;
      end
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    next_state  = state;
    flags_after = ld_flags | (load_en ? rise_abo : 3'b000);
    case (state)
      COLLECT: if (&flags_after) next_state = EXEC;
      EXEC:    next_state = HOLD;
      HOLD:    if (|rise_abo) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) state <= COLLECT;
    else         state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      // All-ones so a button already held at reset release is not seen as a press.
      btn_q      <= '1;
      ld_flags   <= '0;
      reg_a      <= '0;
      reg_b      <= '0;
      reg_op     <= '0;
      o_result   <= '0;
      o_zero     <= 1'b0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      btn_q   <= i_buttons;
      o_valid <= 1'b0;
      if (state == EXEC) begin
        o_result   <= alu_result;
        o_zero     <= (alu_result == '0);
        o_carry    <= alu_carry;
        o_overflow <= alu_ovf;
        o_err      <= alu_err;
        o_valid    <= 1'b1;
        ld_flags   <= '0;
      end else begin
        if (rise_abo[0]) reg_a  <= i_switches;
        if (rise_abo[1]) reg_b  <= i_switches;
        if (rise_abo[2]) reg_op <= i_switches[BITS_OP-1:0];
        ld_flags <= flags_after;
      end
    end
  end

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Self-checking bench: event-level reference model compared every cycle, plus literal pins.
module tb_alu_input_sequencer;

  logic       clk;
  logic       i_reset;
  logic [7:0] i_switches;
  logic [2:0] i_buttons;
  logic [7:0] o_result;
  logic       o_zero, o_carry, o_overflow, o_err, o_valid;
  logic [1:0] o_state;

  int checks = 0;
  int passes = 0;

  alu_input_sequencer #(.BITS_DATA(8), .BITS_OP(6), .BUTTONS(3)) dut (
    .clk(clk), .i_reset(i_reset), .i_switches(i_switches), .i_buttons(i_buttons),
    .o_result(o_result), .o_zero(o_zero), .o_carry(o_carry), .o_overflow(o_overflow),
    .o_err(o_err), .o_valid(o_valid), .o_state(o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pk(input logic [7:0] r, input logic z, input logic c,
                                     input logic v, input logic e, input logic val,
                                     input logic [1:0] st);
    return {1'b0, r, z, c, v, e, val, st};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (res,z,c,v,e,valid,state)", name, act, exp);
  endtask

  function automatic logic [15:0] snap();
    return pk(o_result, o_zero, o_carry, o_overflow, o_err, o_valid, o_state);
  endfunction

  // Reference ALU from plain integer arithmetic
  task automatic ref_alu(input bit [7:0] a, input bit [7:0] b, input bit [5:0] op,
                         output bit [7:0] r, output bit c, output bit v, output bit e);
    int ua, ub, sa, sb, t;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = 8'h00; c = 1'b0; v = 1'b0; e = 1'b0; t = 0;
    case (op)
      6'h20: begin t = ua + ub; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); r = t[7:0]; end
      6'h22: begin t = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); r = t[7:0]; end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: begin t = (ub >= 8) ? ((sa < 0) ? -1 : 0) : (sa >>> ub); r = t[7:0]; end
      6'h02: begin t = (ub >= 8) ? 0 : (ua >> ub); r = t[7:0]; end
      default: e = 1'b1;
    endcase
  endtask

  // Model: phase 0 collecting, 1 executing, 2 holding
  bit       live = 1'b0;
  bit [7:0] m_a, m_b, m_res;
  bit [5:0] m_op;
  bit [2:0] m_flags, m_prev;
  bit       m_z, m_c, m_v, m_e, m_valid;
  int       m_phase;

  always @(posedge clk) begin
    bit [2:0] rise;
    live = 1'b1;
    if (i_reset) begin
      m_a = 0; m_b = 0; m_op = 0; m_flags = 0; m_prev = 3'b111; m_phase = 0;
      m_res = 0; m_z = 0; m_c = 0; m_v = 0; m_e = 0; m_valid = 0;
    end else begin
      rise = i_buttons & ~m_prev;
      m_prev = i_buttons;
      m_valid = 0;
      if (m_phase == 1) begin
        ref_alu(m_a, m_b, m_op, m_res, m_c, m_v, m_e);
        m_z = (m_res == 0);
        m_valid = 1;
        m_flags = 0;
        m_phase = 2;
      end else begin
        if (rise[0]) m_a = i_switches;
        if (rise[1]) m_b = i_switches;
        if (rise[2]) m_op = i_switches[5:0];
        m_flags |= rise;
        if (m_phase == 0 && m_flags == 3'b111) m_phase = 1;
        else if (m_phase == 2 && rise != 0) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (live) check("cycle", snap(), pk(m_res, m_z, m_c, m_v, m_e, m_valid, 2'(m_phase)));
  end

  task automatic press(input logic [2:0] mask, input logic [7:0] sw);
    @(negedge clk);
    i_buttons = mask; i_switches = sw;
    @(negedge clk);
    i_buttons = 3'b000;
    @(negedge clk);
  endtask

  task automatic op3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    press(3'b001, a); press(3'b010, b); press(3'b100, op);
  endtask

  bit [5:0] ops [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02, 6'h3F, 6'h01};

  initial begin
    i_reset = 1'b1; i_buttons = 3'b001; i_switches = 8'h99;
    repeat (3) @(negedge clk);
    check("reset_state", snap(), pk(8'h00, 0, 0, 0, 0, 0, 2'b00));
    i_reset = 1'b0;
    repeat (3) @(negedge clk);
    i_buttons = 3'b000;
    press(3'b010, 8'h01); press(3'b100, 8'h20);
    check("held_through_reset_no_load", snap(), pk(8'h00, 0, 0, 0, 0, 0, 2'b00));
    press(3'b001, 8'h7F);
    check("add_7f_01", snap(), pk(8'h80, 0, 0, 1, 0, 1, 2'b10));
    @(negedge clk);
    check("valid_one_cycle", snap(), pk(8'h80, 0, 0, 1, 0, 0, 2'b10));

    op3(8'h05, 8'h05, 8'h22);
    check("sub_equal", snap(), pk(8'h00, 1, 0, 0, 0, 1, 2'b10));
    press(3'b010, 8'h07);
    check("repress_b_collect", snap(), pk(8'h00, 1, 0, 0, 0, 0, 2'b00));
    press(3'b001, 8'h03); press(3'b100, 8'h22);
    check("sub_borrow", snap(), pk(8'hFC, 0, 1, 0, 0, 1, 2'b10));

    op3(8'h80, 8'h02, 8'h03);
    check("sra_2", snap(), pk(8'hE0, 0, 0, 0, 0, 1, 2'b10));
    op3(8'h80, 8'h02, 8'h02);
    check("srl_2", snap(), pk(8'h20, 0, 0, 0, 0, 1, 2'b10));
    op3(8'h80, 8'h09, 8'h03);
    check("sra_9", snap(), pk(8'hFF, 0, 0, 0, 0, 1, 2'b10));
    op3(8'h80, 8'h09, 8'h02);
    check("srl_9", snap(), pk(8'h00, 1, 0, 0, 0, 1, 2'b10));

    @(negedge clk);
    i_buttons = 3'b001; i_switches = 8'h5A;
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      i_switches = 8'h5A + 8'(i);
    end
    @(negedge clk);
    i_buttons = 3'b000;
    press(3'b010, 8'h00); press(3'b100, 8'h25);
    check("held_a_first_value", snap(), pk(8'h5A, 0, 0, 0, 0, 1, 2'b10));
    press(3'b111, 8'h24);
    @(negedge clk);
    check("triple_and", snap(), pk(8'h24, 0, 0, 0, 0, 1, 2'b10));

    op3(8'h01, 8'h02, 8'h3F);
    check("unknown_op", snap(), pk(8'h00, 1, 0, 0, 1, 1, 2'b10));
    op3(8'h02, 8'h03, 8'h20);
    check("add_clears_err", snap(), pk(8'h05, 0, 0, 0, 0, 1, 2'b10));

    press(3'b001, 8'h01); press(3'b010, 8'h02);
    @(negedge clk);
    i_buttons = 3'b100; i_switches = 8'h20;
    @(negedge clk);
    check("in_exec", {14'b0, o_state}, 16'h0001);
    i_reset = 1'b1; i_buttons = 3'b001;
    @(negedge clk);
    check("reset_in_exec", snap(), pk(8'h00, 0, 0, 0, 0, 0, 2'b00));
    i_reset = 1'b0;
    repeat (2) @(negedge clk);
    i_buttons = 3'b000;
    press(3'b010, 8'h02); press(3'b100, 8'h20);
    check("no_load_after_reset", snap(), pk(8'h00, 0, 0, 0, 0, 0, 2'b00));
    press(3'b001, 8'h04);
    check("add_after_reset", snap(), pk(8'h06, 0, 0, 0, 0, 1, 2'b10));

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      i_reset = ($urandom_range(0, 149) == 0);
      i_buttons = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      if ($urandom_range(0, 1) == 1) i_switches = 8'($urandom);
      else i_switches = {2'($urandom), ops[$urandom_range(0, 9)]};
    end
    i_reset = 1'b0; i_buttons = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_input_sequencer.md
# alu_input_sequencer

Parametrised front-end plus ALU for the board-level ALU design. It converts raw push-button levels into single-shot operand and opcode loads. It fires one registered execution once A, B and OP have all been loaded, and holds the registered result with status flags until the next operation starts. It replaces the plain per-button load registers and adds edge detection, load tracking, flags, an error flag and a valid strobe.

## Interface
- BITS_DATA, 8, operand/result width (≥4)
- BITS_OP, 6, opcode width; opcode = i_switches[BITS_OP-1:0]
- BUTTONS, 3, button count; bit0=A, bit1=B, bit2=OP (extra bits ignored)
- clk  in  1  clock, rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_switches  in  BITS_DATA  load value, signed for A/B
- i_buttons  in  BUTTONS  raw button levels, already synchronised/debounced
- o_result  out  BITS_DATA  registered result, signed
- o_zero  out  1  registered: result == 0
- o_carry  out  1  registered: ADD carry-out / SUB borrow
- o_overflow  out  1  registered: signed overflow on ADD/SUB
- o_err  out  1  registered: unsupported opcode executed
- o_valid  out  1  one-cycle pulse on result update
- o_state  out  2  FSM state: 00 COLLECT, 01 EXEC, 10 HOLD

## Operation
- Edge detect: btn_q <= i_buttons every cycle. rise = i_buttons & ~btn_q.
  - A held button produces exactly one load.
  - btn_q updates in every state, including EXEC.
- Load on rise[i] in COLLECT or HOLD:
  - The register takes i_switches; OP takes the low BITS_OP bits.
  - ld_flag[i] is set.
  - Simultaneous rises all load the same switch value in that cycle.
  - A re-press overwrites the value; its flag stays set.
- FSM:
  - COLLECT: when ld_flags would all be set after this edge's loads -> EXEC.
  - EXEC (exactly 1 cycle): compute from the registered A/B/OP. Update o_result/flags. Pulse o_valid. Clear ld_flags. -> HOLD.
    - Rises seen in EXEC are dropped (not loaded).
  - HOLD: outputs frozen. Any rise -> COLLECT, with that load applied and its flag set. Old result stays visible until the next EXEC.
- Opcodes (BITS_OP=6 encodings, zero-extended/truncated for other widths):
  - ADD 100000: A+B. carry = unsigned carry-out. overflow = operand signs equal and result sign differs.
  - SUB 100010: A-B. carry = borrow (unsigned A<B). overflow = operand signs differ and result sign differs from A.
  - AND 100100, OR 100101, XOR 100110, NOR 100111: bitwise.
  - SRA 000011: A >>> B. SRL 000010: A >> B.
    - B is taken unsigned.
    - For B ≥ BITS_DATA: SRL gives 0; SRA gives all sign bits.
  - Any other opcode: result 0, o_err=1.
- Flag rules:
  - carry/overflow are 0 for all ops other than ADD/SUB.
  - o_zero reflects the result written, including the err case (result 0 -> o_zero=1).
  - o_err=0 for supported ops.
- All result/flag outputs change only at the end of an EXEC cycle.

## Timing
- Reset values:
  - o_result=0, o_zero=0, o_carry=0, o_overflow=0, o_err=0, o_valid=0.
  - o_state=COLLECT.
  - A=B=OP=0, ld_flags=0, btn_q=all-ones, so a button held through reset does not load.
- Reset dominates every other event in the same cycle, including mid-EXEC; the pending result is discarded.
- Load latency: button high at edge k (low at k-1) -> register updated after edge k.
- Execution latency:
  - Final load at edge k -> state EXEC after k.
  - Result/flags updated and o_valid=1 after edge k+1.
  - o_valid=0 again after edge k+2 (state HOLD).
- Back-to-back: minimum 3 clock edges between successive o_valid pulses (three loads can coincide at one edge).

## Test plan
- BITS_DATA=8, ADD 0x7F+0x01 (separate presses A, B, OP) -> o_result=0x80, overflow=1, carry=0, zero=0; o_valid one cycle, 1 edge after the OP load.
- SUB 0x05-0x05 -> result 0x00, zero=1, carry=0. Then re-press only B=0x07 -> stays COLLECT, no o_valid. Then press A (0x03) and OP (SUB) -> 0xFC, carry=1, overflow=0.
- SRA A=0x80, B=2 -> 0xE0. SRL same operands -> 0x20. SRA with B=9 -> 0xFF. SRL with B=9 -> 0x00.
- A held high 10 cycles with switches changing each cycle -> A equals the switch value of the first cycle only; then press A, B and OP in the same cycle (switches=0x24, AND) -> result 0x24.
- Unknown opcode 0x3F -> o_result=0, o_err=1, o_zero=1. Then a valid ADD -> o_err=0.
- Assert i_reset in the EXEC cycle -> no o_valid, all outputs 0, o_state=00. A button held through reset -> no load.
